// File: rtl/sdrc_mcb_arb2.sv
// ----------------------------------------------------------------------------
// sdrc_mcb_arb2
// Two-port command arbiter in front of an SDRAM controller back-end (MCB).
// Each requester holds a level request with its command fields. The arbiter
// picks a winner in IDLE, registers that command onto mcb_* with a one-cycle
// mcb_bb strobe and acks the winner. It then tracks the back-end mcb_busy
// handshake (rise, then fall) before accepting the next request. Write-data
// requests, read-data valids and write data are routed to or from the owner.
//
// Ports
//   mcb_clk, mcb_rst          clock, asynchronous active-high reset
//   pN_req                    level request, held until pN_ack
//   pN_wr_n/bl/ba/ra/ca       command fields, stable while pN_req is high
//   pN_ack                    one-cycle accept pulse
//   pN_wdat_req, pN_rdat_vld  back-end data handshakes routed to the owner
//   pN_wdat                   write data from port N
//   mcb_bb, mcb_wr_n, mcb_bl,
//   mcb_ba, mcb_ra, mcb_ca    registered command toward the back-end
//   mcb_busy                  back-end busy (handshake for each command)
//   mcb_wdat_req, mcb_rdat_vld back-end data handshakes
//   mcb_wdat                  write data muxed from the owner
//   arb_to                    one-cycle pulse: mcb_busy never rose after issue
//
// Build option
//   MCB_ARB_FIXED_PRI_EN      defined: port 0 wins every tie
//                             undefined: round-robin between the two ports
// ----------------------------------------------------------------------------
// state   | meaning
// IDLE    | ready; grant on an edge with mcb_busy low and a request present
// ISSUE   | mcb_bb strobe cycle; the command fields stay registered
// WAIT_HI | waiting for mcb_busy to rise; the guard timer runs here
// WAIT_LO | waiting for mcb_busy to fall; then IDLE without a same-edge grant
// ----------------------------------------------------------------------------
module sdrc_mcb_arb2 #(
   parameter int MCB_B_W = 2,
   parameter int MCB_R_W = 12,
   parameter int MCB_C_W = 8,
   parameter int MCB_D_W = 16
) (
   input  logic               mcb_clk,
   input  logic               mcb_rst,
   input  logic               p0_req,
   input  logic               p0_wr_n,
   input  logic [1:0]         p0_bl,
   input  logic [MCB_B_W-1:0] p0_ba,
   input  logic [MCB_R_W-1:0] p0_ra,
   input  logic [MCB_C_W-1:0] p0_ca,
   output logic               p0_ack,
   output logic               p0_wdat_req,
   input  logic [MCB_D_W-1:0] p0_wdat,
   output logic               p0_rdat_vld,
   input  logic               p1_req,
   input  logic               p1_wr_n,
   input  logic [1:0]         p1_bl,
   input  logic [MCB_B_W-1:0] p1_ba,
   input  logic [MCB_R_W-1:0] p1_ra,
   input  logic [MCB_C_W-1:0] p1_ca,
   output logic               p1_ack,
   output logic               p1_wdat_req,
   input  logic [MCB_D_W-1:0] p1_wdat,
   output logic               p1_rdat_vld,
   output logic               mcb_bb,
   output logic               mcb_wr_n,
   output logic [1:0]         mcb_bl,
   output logic [MCB_B_W-1:0] mcb_ba,
   output logic [MCB_R_W-1:0] mcb_ra,
   output logic [MCB_C_W-1:0] mcb_ca,
   input  logic               mcb_busy,
   input  logic               mcb_wdat_req,
   input  logic               mcb_rdat_vld,
   output logic [MCB_D_W-1:0] mcb_wdat,
   output logic               arb_to
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_HI = 2'd2,
      ST_WAIT_LO = 2'd3
   } state_t;

   // Loaded on entry to WAIT_HI; terminal count 0 after 8 idle-busy edges.
   localparam logic [2:0] GUARD_LD = 3'd7;

   state_t     state;
   logic       owner;
   logic [2:0] guard;
   logic       gnt_go;
   logic       gnt_p1;
   logic       in_txn;

   assign gnt_go = (state == ST_IDLE) && !mcb_busy && (p0_req || p1_req);

`ifdef MCB_ARB_FIXED_PRI_EN
   assign gnt_p1 = p1_req && !p0_req;
`else
   // last_gnt = 1 means port 1 was granted last; reset value lets port 0 win
   // the first tie.
   logic last_gnt;

   assign gnt_p1 = p1_req && (!p0_req || !last_gnt);

   always_ff @(posedge mcb_clk or posedge mcb_rst) begin
      if (mcb_rst)
         last_gnt <= 1'b1;
      else if (gnt_go)
         last_gnt <= gnt_p1;
   end
`endif

   always_ff @(posedge mcb_clk or posedge mcb_rst) begin
      if (mcb_rst) begin
         state    <= ST_IDLE;
         owner    <= 1'b0;
         guard    <= '0;
         mcb_bb   <= 1'b0;
         mcb_wr_n <= 1'b0;
         mcb_bl   <= '0;
         mcb_ba   <= '0;
         mcb_ra   <= '0;
         mcb_ca   <= '0;
         p0_ack   <= 1'b0;
         p1_ack   <= 1'b0;
         arb_to   <= 1'b0;
      end else begin
         mcb_bb <= 1'b0;
         p0_ack <= 1'b0;
         p1_ack <= 1'b0;
         arb_to <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gnt_go) begin
                  owner    <= gnt_p1;
                  mcb_bb   <= 1'b1;
                  p0_ack   <= !gnt_p1;
                  p1_ack   <= gnt_p1;
                  mcb_wr_n <= gnt_p1 ? p1_wr_n : p0_wr_n;
                  mcb_bl   <= gnt_p1 ? p1_bl   : p0_bl;
                  mcb_ba   <= gnt_p1 ? p1_ba   : p0_ba;
                  mcb_ra   <= gnt_p1 ? p1_ra   : p0_ra;
                  mcb_ca   <= gnt_p1 ? p1_ca   : p0_ca;
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               guard <= GUARD_LD;
               state <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (mcb_busy) begin
                  state <= ST_WAIT_LO;
               end else if (guard == 3'd0) begin
                  arb_to <= 1'b1;
                  state  <= ST_IDLE;
               end else begin
                  guard <= guard - 3'd1;
               end
            end
            ST_WAIT_LO: begin
               if (!mcb_busy)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_txn      = (state != ST_IDLE);
   assign p0_wdat_req = mcb_wdat_req && in_txn && !owner;
   assign p1_wdat_req = mcb_wdat_req && in_txn &&  owner;
   assign p0_rdat_vld = mcb_rdat_vld && in_txn && !owner;
   assign p1_rdat_vld = mcb_rdat_vld && in_txn &&  owner;
   assign mcb_wdat    = owner ? p1_wdat : p0_wdat;

endmodule

// File: tb/tb_sdrc_mcb_arb2.sv
module tb_sdrc_mcb_arb2;

   logic        mcb_clk = 1'b0;
   logic        mcb_rst = 1'b1;
   logic        p0_req = 0, p0_wr_n = 0, p1_req = 0, p1_wr_n = 0;
   logic [1:0]  p0_bl = 0, p1_bl = 0, p0_ba = 0, p1_ba = 0;
   logic [11:0] p0_ra = 0, p1_ra = 0;
   logic [7:0]  p0_ca = 0, p1_ca = 0;
   logic [15:0] p0_wdat = 0, p1_wdat = 0;
   logic        p0_ack, p1_ack, p0_wdat_req, p1_wdat_req, p0_rdat_vld, p1_rdat_vld;
   logic        mcb_bb, mcb_wr_n, arb_to;
   logic [1:0]  mcb_bl, mcb_ba;
   logic [11:0] mcb_ra;
   logic [7:0]  mcb_ca;
   logic [15:0] mcb_wdat;
   logic        mcb_busy;
   logic        mcb_wdat_req = 0, mcb_rdat_vld = 0;

   sdrc_mcb_arb2 dut (
      .mcb_clk(mcb_clk), .mcb_rst(mcb_rst),
      .p0_req(p0_req), .p0_wr_n(p0_wr_n), .p0_bl(p0_bl), .p0_ba(p0_ba),
      .p0_ra(p0_ra), .p0_ca(p0_ca), .p0_ack(p0_ack), .p0_wdat_req(p0_wdat_req),
      .p0_wdat(p0_wdat), .p0_rdat_vld(p0_rdat_vld),
      .p1_req(p1_req), .p1_wr_n(p1_wr_n), .p1_bl(p1_bl), .p1_ba(p1_ba),
      .p1_ra(p1_ra), .p1_ca(p1_ca), .p1_ack(p1_ack), .p1_wdat_req(p1_wdat_req),
      .p1_wdat(p1_wdat), .p1_rdat_vld(p1_rdat_vld),
      .mcb_bb(mcb_bb), .mcb_wr_n(mcb_wr_n), .mcb_bl(mcb_bl), .mcb_ba(mcb_ba),
      .mcb_ra(mcb_ra), .mcb_ca(mcb_ca), .mcb_busy(mcb_busy),
      .mcb_wdat_req(mcb_wdat_req), .mcb_rdat_vld(mcb_rdat_vld),
      .mcb_wdat(mcb_wdat), .arb_to(arb_to)
   );

   always #5 mcb_clk = ~mcb_clk;

   typedef struct {
      int          port;
      logic        wr_n;
      logic [1:0]  bl;
      logic [1:0]  ba;
      logic [11:0] ra;
      logic [7:0]  ca;
   } grant_t;

   typedef struct {
      grant_t      g;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [15:0] exp_wdat;
   } vec_t;

   grant_t sbq[$];
   int     n_chk = 0;
   int     n_fail = 0;
   int     cyc = 0;
   bit     to_allow = 0;

   // back-end model: busy for be_len cycles after each mcb_bb strobe
   bit     be_en = 1;
   int     be_len = 6;
   int     be_cnt = 0;
   bit     busy_force = 0;

   always @(posedge mcb_clk) cyc <= cyc + 1;

   always @(posedge mcb_clk or posedge mcb_rst)
      if (mcb_rst)                be_cnt <= 0;
      else if (be_en && mcb_bb)   be_cnt <= be_len;
      else if (be_cnt > 0)        be_cnt <= be_cnt - 1;

   assign mcb_busy = busy_force || (be_cnt > 0);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic grant_t mk(int port, logic wr_n, logic [1:0] bl, logic [1:0] ba,
                                 logic [11:0] ra, logic [7:0] ca);
      grant_t g;
      g.port = port; g.wr_n = wr_n; g.bl = bl; g.ba = ba; g.ra = ra; g.ca = ca;
      return g;
   endfunction

   task automatic drive_port(input grant_t g);
      if (g.port == 0) begin
         p0_wr_n = g.wr_n; p0_bl = g.bl; p0_ba = g.ba; p0_ra = g.ra; p0_ca = g.ca;
      end else begin
         p1_wr_n = g.wr_n; p1_bl = g.bl; p1_ba = g.ba; p1_ra = g.ra; p1_ca = g.ca;
      end
   endtask

   task automatic wait_ack(output int c);
      bit got;
      got = 0;
      c = cyc;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge mcb_clk);
         if (p0_ack || p1_ack) begin
            got = 1;
            c = cyc;
         end
      end
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL ack_wait actual=no_ack required=ack_within_40_cycles");
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge mcb_clk);
   endtask

   // scoreboard consumer: every mcb_bb strobe must match the oldest expected grant
   always @(negedge mcb_clk) begin
      grant_t e;
      if (!mcb_rst) begin
         if (mcb_bb) begin
            if (sbq.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL sb_unexpected_grant actual=bb_p0ack%0d_p1ack%0d required=no_grant", p0_ack, p1_ack);
            end else begin
               e = sbq.pop_front();
               chk("sb_p0_ack", 32'(p0_ack), 32'(e.port == 0));
               chk("sb_p1_ack", 32'(p1_ack), 32'(e.port == 1));
               chk("sb_wr_n", 32'(mcb_wr_n), 32'(e.wr_n));
               chk("sb_bl", 32'(mcb_bl), 32'(e.bl));
               chk("sb_ba", 32'(mcb_ba), 32'(e.ba));
               chk("sb_ra", 32'(mcb_ra), 32'(e.ra));
               chk("sb_ca", 32'(mcb_ca), 32'(e.ca));
            end
         end else if (p0_ack || p1_ack) begin
            n_chk++; n_fail++;
            $display("FAIL ack_without_bb actual=p0ack%0d_p1ack%0d required=0", p0_ack, p1_ack);
         end
         if (arb_to && !to_allow) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_arb_to actual=1 required=0");
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_bb"}, 32'(mcb_bb), 0);
      chk({tag, "_wr_n"}, 32'(mcb_wr_n), 0);
      chk({tag, "_bl"}, 32'(mcb_bl), 0);
      chk({tag, "_ba"}, 32'(mcb_ba), 0);
      chk({tag, "_ra"}, 32'(mcb_ra), 0);
      chk({tag, "_ca"}, 32'(mcb_ca), 0);
      chk({tag, "_acks"}, 32'({p0_ack, p1_ack}), 0);
      chk({tag, "_arb_to"}, 32'(arb_to), 0);
   endtask

   vec_t vecs[4];
   grant_t ga, gb;
   int c0, c1, cnt0, cnt1, bad, seen;

   initial begin
      vecs[0] = '{mk(0, 1'b0, 2'b01, 2'd1, 12'h005, 8'h10), 16'h1111, 16'h2222, 16'h1111};
      vecs[1] = '{mk(1, 1'b1, 2'b10, 2'd2, 12'hABC, 8'h5A), 16'h3333, 16'h4444, 16'h4444};
      vecs[2] = '{mk(0, 1'b1, 2'b11, 2'd3, 12'hFFF, 8'hFF), 16'h5555, 16'h6666, 16'h5555};
      vecs[3] = '{mk(1, 1'b0, 2'b00, 2'd0, 12'h800, 8'h01), 16'h7777, 16'h8888, 16'h8888};

      // reset state
      mcb_wdat_req = 1; mcb_rdat_vld = 1; p0_wdat = 16'hBEEF; p1_wdat = 16'h0F0F;
      idle_cycles(2);
      chk_all_zero("rst");
      chk("rst_wdat_req", 32'({p0_wdat_req, p1_wdat_req}), 0);
      chk("rst_rdat_vld", 32'({p0_rdat_vld, p1_rdat_vld}), 0);
      chk("rst_wdat_owner0", 32'(mcb_wdat), 32'h0000BEEF);
      mcb_wdat_req = 0; mcb_rdat_vld = 0;
      mcb_rst = 0;
      idle_cycles(2);

      // table-driven single-requester grants with data routing
      for (int i = 0; i < 4; i++) begin
         drive_port(vecs[i].g);
         p0_wdat = vecs[i].w0; p1_wdat = vecs[i].w1;
         sbq.push_back(vecs[i].g);
         if (vecs[i].g.port == 0) p0_req = 1; else p1_req = 1;
         wait_ack(c0);
         p0_req = 0; p1_req = 0;
         mcb_rdat_vld = 1; mcb_wdat_req = 1;
         #1;
         chk("vec_p0_rdat_vld", 32'(p0_rdat_vld), 32'(vecs[i].g.port == 0));
         chk("vec_p1_rdat_vld", 32'(p1_rdat_vld), 32'(vecs[i].g.port == 1));
         chk("vec_p0_wdat_req", 32'(p0_wdat_req), 32'(vecs[i].g.port == 0));
         chk("vec_p1_wdat_req", 32'(p1_wdat_req), 32'(vecs[i].g.port == 1));
         chk("vec_mcb_wdat", 32'(mcb_wdat), 32'(vecs[i].exp_wdat));
         mcb_rdat_vld = 0; mcb_wdat_req = 0;
         idle_cycles(16);
         mcb_rdat_vld = 1; mcb_wdat_req = 1;
         #1;
         chk("idle_rdat_gated", 32'({p0_rdat_vld, p1_rdat_vld}), 0);
         chk("idle_wdat_gated", 32'({p0_wdat_req, p1_wdat_req}), 0);
         mcb_rdat_vld = 0; mcb_wdat_req = 0;
      end

      // busy high in IDLE, rising together with the request
      ga = mk(0, 1'b1, 2'b10, 2'd1, 12'h123, 8'h45);
      drive_port(ga);
      busy_force = 1; p0_req = 1;
      seen = 0;
      repeat (5) begin
         @(negedge mcb_clk);
         if (mcb_bb) seen++;
      end
      chk("busy_idle_no_bb", 32'(seen), 0);
      sbq.push_back(ga);
      busy_force = 0;
      c1 = cyc;
      wait_ack(c0);
      p0_req = 0;
      chk("busy_release_latency", 32'(c0 - c1), 1);
      idle_cycles(16);

      // write burst owned by port 1
      be_len = 10;
      p0_wdat = 16'h1234; p1_wdat = 16'hA5A5;
      gb = mk(1, 1'b0, 2'b11, 2'd2, 12'h0F0, 8'h33);
      drive_port(gb);
      sbq.push_back(gb);
      p1_req = 1;
      wait_ack(c0);
      p1_req = 0;
      cnt0 = 0; cnt1 = 0; bad = 0;
      mcb_wdat_req = 1;
      for (int i = 0; i < 8; i++) begin
         #1;
         cnt0 += int'(p0_wdat_req);
         cnt1 += int'(p1_wdat_req);
         if (mcb_wdat !== 16'hA5A5) bad++;
         @(negedge mcb_clk);
      end
      mcb_wdat_req = 0;
      chk("burst_p1_wdat_req", 32'(cnt1), 8);
      chk("burst_p0_wdat_req", 32'(cnt0), 0);
      chk("burst_wdat_bad", 32'(bad), 0);
      idle_cycles(16);
      be_len = 6;

      // busy never rises -> guard timeout
      be_en = 0; to_allow = 1;
      ga = mk(0, 1'b0, 2'b01, 2'd3, 12'h777, 8'h88);
      drive_port(ga);
      sbq.push_back(ga);
      p0_req = 1;
      wait_ack(c0);
      p0_req = 0;
      seen = 0;
      c1 = c0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge mcb_clk);
         if (arb_to) begin seen = 1; c1 = cyc; end
      end
      chk("to_seen", 32'(seen), 1);
      chk("to_latency", 32'(c1 - c0), 9);
      sbq.push_back(ga);
      p0_req = 1;
      wait_ack(c0);
      p0_req = 0;
      chk("to_pulse_width", 32'(arb_to), 0);
      chk("to_regrant_latency", 32'(c0 - c1), 1);
      idle_cycles(14);
      be_en = 1; to_allow = 0;

      // both ports held from reset: arbitration order
      mcb_rst = 1;
      idle_cycles(2);
      ga = mk(0, 1'b1, 2'b01, 2'd1, 12'h111, 8'h11);
      gb = mk(1, 1'b0, 2'b10, 2'd2, 12'h222, 8'h22);
      drive_port(ga); drive_port(gb);
`ifdef MCB_ARB_FIXED_PRI_EN
      sbq.push_back(ga); sbq.push_back(ga); sbq.push_back(ga); sbq.push_back(ga);
`else
      sbq.push_back(ga); sbq.push_back(gb); sbq.push_back(ga); sbq.push_back(gb);
`endif
      sbq.push_back(gb);
      p0_req = 1; p1_req = 1;
      mcb_rst = 0;
      wait_ack(c1);
      for (int i = 1; i < 5; i++) begin
         if (i == 4) p0_req = 0;
         wait_ack(c0);
         chk("arb_spacing", 32'(c0 - c1), 9);
         c1 = c0;
      end
      p1_req = 0;
      idle_cycles(16);

      // reset in WAIT_LO with a pending port 1 request
      be_len = 10;
      ga = mk(0, 1'b1, 2'b11, 2'd2, 12'h3C3, 8'h77);
      gb = mk(1, 1'b1, 2'b01, 2'd1, 12'h5A5, 8'h66);
      drive_port(ga); drive_port(gb);
      sbq.push_back(ga);
      p0_req = 1;
      wait_ack(c0);
      p0_req = 0;
      p1_req = 1;
      idle_cycles(3);
      mcb_rst = 1;
      #1;
      chk_all_zero("midrst");
      idle_cycles(1);
      sbq.push_back(gb);
      mcb_rst = 0;
      c1 = cyc;
      wait_ack(c0);
      p1_req = 0;
      chk("midrst_regrant_latency", 32'(c0 - c1), 1);
      idle_cycles(16);

      chk("sb_drained", 32'(sbq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
